// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS register window, byte FIFO, serial frame engine.
// Build option UART_TX_PARITY_EN adds an even-parity bit (8E1); the default build sends 8N1.
module mmio_uart_tx #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h1000_0000),
    parameter int unsigned           FIFO_DEPTH   = 16,
    parameter int unsigned           CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [3:0]            wmask,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  hit,
    output logic                  tx
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [2:0]    bit_q,    bit_d;
    logic [7:0]    shreg_q,  shreg_d;
    logic          tx_q,     tx_d;
    logic          ovf_q,    ovf_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          full, empty, busy, bit_end;
    logic          txdata_wr, status_wr, push, pop;
    logic [PW-1:0] count;
    logic [7:0]    rd_data;
    logic [31:0]   status;
    logic          unused_bits;

    // Register decode and FIFO flags
    assign hit       = (addr[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3]);
    assign txdata_wr = we & hit & ~addr[2] & wmask[0];
    assign status_wr = we & hit &  addr[2] & wmask[0];
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count     = wr_ptr_q - rd_ptr_q;
    assign push      = txdata_wr & ~full;
    assign busy      = (state_q != S_IDLE);
    assign rd_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign bit_end   = (cnt_q == CW'(CLKS_PER_BIT - 1));

    assign status   = {16'h0000, 8'(count), 4'h0, ovf_q, busy, empty, full};
    assign data_out = (hit && addr[2]) ? DATA_WIDTH'(status) : '0;
    assign tx       = tx_q;

    assign unused_bits = ^{addr[1:0], wmask[3:1], data_in[DATA_WIDTH-1:8]};

    // Next-state: serial engine, FIFO pointers, sticky overflow
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        ovf_d    = ovf_q;
        pop      = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = rd_data;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        // Rotation preserves the XOR, so shreg still yields the byte's parity
                        state_d = S_PARITY;
                        tx_d    = ^shreg_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {shreg_q[0], shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = rd_data;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                cnt_d   = '0;
                bit_d   = 3'd0;
            end
        endcase

        if (txdata_wr && full) begin
            ovf_d = 1'b1;
        end else if (status_wr && data_in[3]) begin
            ovf_d = 1'b0;
        end

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            shreg_q  <= 8'h00;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are left stale on reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in[7:0];
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a UART receiver model decodes tx frames and
// the tests compare them, and STATUS reads, against expectations built from the register rules.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
    localparam int unsigned CPB   = 16;
    localparam logic [31:0] BASE  = 32'h1000_0000;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] data_in = 32'h0;
    logic [3:0]  wmask = 4'h0;
    logic        we = 1'b0;
    logic [31:0] data_out;
    logic        hit;
    logic        tx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    byte unsigned rx_q[$];
    bit           rx_ok_q[$];
    bit           rx_par_q[$];
    int           rx_t_q[$];

    mmio_uart_tx #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (16),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .data_in (data_in),
        .wmask   (wmask),
        .we      (we),
        .data_out(data_out),
        .hit     (hit),
        .tx      (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART receiver: detect start, sample every bit at mid-bit time
    initial begin : monitor
        logic [7:0] b;
        logic       ok;
        logic       p;
        int         t0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                t0 = cyc;
                ok = 1'b1;
                p  = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                if (tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                p = tx;
                if (p !== ^b) ok = 1'b0;
`endif
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) ok = 1'b0;
                rx_q.push_back(b);
                rx_ok_q.push_back(ok);
                rx_par_q.push_back(p);
                rx_t_q.push_back(t0);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        addr = a; data_in = d; wmask = m; we = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        #1 d = data_out;
    endtask

    task automatic clear_rx();
        rx_q.delete(); rx_ok_q.delete(); rx_par_q.delete(); rx_t_q.delete();
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) break;
            @(posedge clk);
        end
        repeat (CPB) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        load(BASE + 32'h4, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h want 00000002", d); end
        n_checks++;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL reset_hit_status: got %b want 1", hit); end
        load(32'h0, d);
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit_zero: got %b want 0", hit); end
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_miss_data: got %h want 0", d); end
        load(BASE, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got %h want 0", d); end
    endtask

    task automatic test_single_byte();
        logic [31:0] d;
        clear_rx();
        store(BASE, 32'h0000_0055, 4'b0001);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL single_pre_tx: got %b want 1", tx); end
        @(posedge clk); #1;
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL single_start_fall: got %b want 0", tx); end
        repeat (FRAME - 1) @(posedge clk);
        load(BASE + 32'h4, d);
        n_checks++;
        if (d !== 32'h6) begin n_fail++; $display("FAIL single_busy_last: got %h want 00000006", d); end
        @(posedge clk);
        load(BASE + 32'h4, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL single_idle_after: got %h want 00000002", d); end
        n_checks++;
        if (rx_q.size() != 1) begin
            n_fail++; $display("FAIL single_nframes: got %0d want 1", rx_q.size());
        end else begin
            n_checks++;
            if (rx_q[0] != 8'h55) begin n_fail++; $display("FAIL single_byte: got %h want 55", rx_q[0]); end
            n_checks++;
            if (rx_ok_q[0] != 1'b1) begin n_fail++; $display("FAIL single_framing: got %b want 1", rx_ok_q[0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        byte unsigned exp_b[3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        clear_rx();
        for (int i = 0; i < 3; i++) store(BASE, 32'(exp_b[i]), 4'b0001);
        load(BASE + 32'h4, d);
        n_checks++;
        if (d !== 32'h0000_0204) begin n_fail++; $display("FAIL b2b_count: got %h want 00000204", d); end
        wait_frames(3, 4 * FRAME);
        n_checks++;
        if (rx_q.size() != 3) begin
            n_fail++; $display("FAIL b2b_nframes: got %0d want 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (rx_q[i] != exp_b[i] || !rx_ok_q[i]) begin
                    n_fail++; $display("FAIL b2b_byte%0d: got %h ok=%b want %h ok=1", i, rx_q[i], rx_ok_q[i], exp_b[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (rx_t_q[i] - rx_t_q[i-1] != int'(FRAME)) begin
                    n_fail++; $display("FAIL b2b_gap%0d: got %0d cycles want %0d", i, rx_t_q[i] - rx_t_q[i-1], FRAME);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, dv;
        logic [3:0]  m;
        logic        exp_hit;
        byte unsigned exp_q[$];
        for (int r = 0; r < 4; r++) begin
            clear_rx();
            exp_q.delete();
            for (int i = 0; i < int'($urandom_range(3, 8)); i++) begin
                a  = ($urandom_range(0, 3) == 0) ? $urandom() : BASE + $urandom_range(0, 15);
                m  = 4'($urandom());
                dv = $urandom();
                if (i == 0) begin a = BASE; m = 4'b0001; end
                if (a[31:3] == BASE[31:3] && !a[2] && m[0]) exp_q.push_back(dv[7:0]);
                store(a, dv, m);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            a = ($urandom_range(0, 1) == 0) ? $urandom() : BASE + $urandom_range(0, 15);
            exp_hit = (a[31:3] == BASE[31:3]);
            load(a, d);
            n_checks++;
            if (hit !== exp_hit) begin n_fail++; $display("FAIL rand_hit %h: got %b want %b", a, hit, exp_hit); end
            if (!exp_hit || !a[2]) begin
                n_checks++;
                if (d !== 32'h0) begin n_fail++; $display("FAIL rand_rdata %h: got %h want 0", a, d); end
            end
            wait_frames(exp_q.size(), (exp_q.size() + 1) * FRAME);
            n_checks++;
            if (rx_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL rand_nframes r%0d: got %0d want %0d", r, rx_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_checks++;
                    if (rx_q[i] != exp_q[i] || !rx_ok_q[i]) begin
                        n_fail++; $display("FAIL rand_byte r%0d i%0d: got %h ok=%b want %h ok=1", r, i, rx_q[i], rx_ok_q[i], exp_q[i]);
                    end
                    if (i > 0) begin
                        n_checks++;
                        if (rx_t_q[i] - rx_t_q[i-1] != int'(FRAME)) begin
                            n_fail++; $display("FAIL rand_gap r%0d i%0d: got %0d want %0d", r, i, rx_t_q[i] - rx_t_q[i-1], FRAME);
                        end
                    end
                end
            end
            load(BASE + 32'h4, d);
            n_checks++;
            if (d !== 32'h2) begin n_fail++; $display("FAIL rand_idle r%0d: got %h want 00000002", r, d); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        byte unsigned exp_q[$];
        clear_rx();
        store(BASE, 32'hA0, 4'b0001);
        exp_q.push_back(8'hA0);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 17; i++) begin
            store(BASE, 32'(8'hB0 + i), 4'b0001);
            if (i < 16) exp_q.push_back(8'(8'hB0 + i));
        end
        load(BASE + 32'h4, d);
        n_checks++;
        if (d !== 32'h0000_100D) begin n_fail++; $display("FAIL ovf_status: got %h want 0000100d", d); end
        store(BASE + 32'h4, 32'hFFFF_FFF7, 4'b0001);
        load(BASE + 32'h4, d);
        n_checks++;
        if (d !== 32'h0000_100D) begin n_fail++; $display("FAIL ovf_noclear: got %h want 0000100d", d); end
        store(BASE + 32'h4, 32'h8, 4'b0001);
        load(BASE + 32'h4, d);
        n_checks++;
        if (d !== 32'h0000_1005) begin n_fail++; $display("FAIL ovf_clear: got %h want 00001005", d); end
        wait_frames(17, 18 * FRAME);
        n_checks++;
        if (rx_q.size() != 17) begin
            n_fail++; $display("FAIL ovf_nframes: got %0d want 17", rx_q.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                n_checks++;
                if (rx_q[i] != exp_q[i] || !rx_ok_q[i]) begin
                    n_fail++; $display("FAIL ovf_byte%0d: got %h ok=%b want %h ok=1", i, rx_q[i], rx_ok_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_masking();
        logic [31:0] d;
        int lows;
        clear_rx();
        store(BASE, 32'h99, 4'b0010);
        load(BASE + 32'h4, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL mask_lane1: got %h want 00000002", d); end
        store(BASE, 32'h99, 4'b1110);
        load(BASE + 32'h8, d);
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL mask_hit8: got %b want 0", hit); end
        store(BASE + 32'h8, 32'h99, 4'b0001);
        load(BASE + 32'h4, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL mask_miss_push: got %h want 00000002", d); end
        lows = 0;
        for (int i = 0; i < int'(2 * FRAME); i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0 || rx_q.size() != 0) begin
            n_fail++; $display("FAIL mask_quiet: got %0d low cycles %0d frames want 0 0", lows, rx_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        int lows;
        clear_rx();
        store(BASE, 32'h3C, 4'b0001);
        store(BASE, 32'h5A, 4'b0001);
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b want 1", tx); end
        rst = 1'b1;
        load(BASE + 32'h4, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL midrst_status: got %h want 00000002", d); end
        lows = 0;
        for (int i = 0; i < int'(3 * FRAME); i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d low cycles want 0", lows); end
        clear_rx();
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        clear_rx();
        store(BASE, 32'h07, 4'b0001);
        wait_frames(1, 2 * FRAME);
        n_checks++;
        if (rx_q.size() != 1) begin
            n_fail++; $display("FAIL par_nframes: got %0d want 1", rx_q.size());
        end else begin
            n_checks++;
            if (rx_par_q[0] != 1'b1 || rx_q[0] != 8'h07 || !rx_ok_q[0]) begin
                n_fail++; $display("FAIL par_bit: got par=%b byte=%h ok=%b want par=1 byte=07 ok=1", rx_par_q[0], rx_q[0], rx_ok_q[0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_random();
        test_overflow();
        test_masking();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
